// File: rtl/blink.sv
// Free-running LED blinker: led toggles once every CDIV clocks, so the period is 2*CDIV.
// State is a wrap-around counter plus the led flop; reset loads counter=0, led=INIT.
module blink #(
    parameter int CDIV = 3,
    parameter bit INIT = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    output logic led
);

    // CDIV==1 still needs a 1-bit counter; it simply never leaves 0
    localparam int            CW   = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CDIV - 1);

    logic [CW-1:0] counter;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            counter <= '0;
            led     <= INIT;
        end else if (counter == LAST) begin
            counter <= '0;
            led     <= ~led;
        end else begin
            counter <= counter + 1'b1;
        end
    end

endmodule

// File: tb/tb_blink.sv
// Bench for blink: a directed vector table on CDIV=3/INIT=1, a hand sequence on CDIV=1/INIT=0,
// then random reset/run traffic on both against an edges-since-reset arithmetic model.
module tb_blink;

    logic clk    = 1'b0;
    logic n_rst3 = 1'b1;
    logic n_rst1 = 1'b1;
    logic led3, led1;

    int checks = 0;
    int errors = 0;

    blink #(.CDIV(3), .INIT(1'b1)) dut3 (.clk(clk), .n_rst(n_rst3), .led(led3));
    blink #(.CDIV(1), .INIT(1'b0)) dut1 (.clk(clk), .n_rst(n_rst1), .led(led1));

    // act: 0 = pulse reset low (checked while low and just after release), 1 = one clk edge
    typedef struct {
        int act;
        int cnt;
        bit led;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // one rising edge; returns with clk low, well away from the edge
    task automatic tick();
        #4 clk = 1'b1;
        #5 clk = 1'b0;
        #1;
    endtask

    vec_t vecs[$];
    int   k3, k1;

    initial begin
        // edges 1..3, then 4..11 (REQ-019 waveform), reset at cnt=2/led=0, then 3 edges to first toggle
        vecs = '{
            '{0, 0, 1'b1},
            '{1, 1, 1'b1}, '{1, 2, 1'b1}, '{1, 0, 1'b0},
            '{1, 1, 1'b0}, '{1, 2, 1'b0}, '{1, 0, 1'b1}, '{1, 1, 1'b1},
            '{1, 2, 1'b1}, '{1, 0, 1'b0}, '{1, 1, 1'b0}, '{1, 2, 1'b0},
            '{0, 0, 1'b1},
            '{1, 1, 1'b1}, '{1, 2, 1'b1}, '{1, 0, 1'b0}
        };

        #1;
        n_rst3 = 1'b0;
        n_rst1 = 1'b0;
        #1;
        chk("rst_cnt3", int'(dut3.counter), 0);
        chk("rst_led3", int'(led3), 1);
        chk("rst_cnt1", int'(dut1.counter), 0);
        chk("rst_led1", int'(led1), 0);
        n_rst3 = 1'b1;
        #1;

        foreach (vecs[i]) begin
            if (vecs[i].act == 0) begin
                n_rst3 = 1'b0;
                #1;
                chk($sformatf("v%0d_rst_cnt", i), int'(dut3.counter), vecs[i].cnt);
                chk($sformatf("v%0d_rst_led", i), int'(led3), int'(vecs[i].led));
                n_rst3 = 1'b1;
                #1;
                chk($sformatf("v%0d_rel_cnt", i), int'(dut3.counter), vecs[i].cnt);
                chk($sformatf("v%0d_rel_led", i), int'(led3), int'(vecs[i].led));
            end else begin
                tick();
                chk($sformatf("v%0d_cnt", i), int'(dut3.counter), vecs[i].cnt);
                chk($sformatf("v%0d_led", i), int'(led3), int'(vecs[i].led));
            end
        end
        // dut1 has been held in reset throughout: it must still show INIT
        chk("cd1_held_led", int'(led1), 0);
        chk("cd1_held_cnt", int'(dut1.counter), 0);

        // CDIV=1: alternate every edge, counter pinned at 0
        n_rst1 = 1'b1;
        #1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("cd1_e%0d_led", e), int'(led1), e % 2);
            chk($sformatf("cd1_e%0d_cnt", e), int'(dut1.counter), 0);
        end

        // restart both cleanly, then 30 free-running edges followed by random resets
        n_rst3 = 1'b0;
        n_rst1 = 1'b0;
        #1;
        n_rst3 = 1'b1;
        n_rst1 = 1'b1;
        #1;
        k3 = 0;
        k1 = 0;
        for (int n = 0; n < 300; n++) begin
            if (n >= 30 && $urandom_range(0, 11) == 0) begin
                n_rst3 = 1'b0;
                #1;
                k3 = 0;
                chk("rnd_rst_cnt3", int'(dut3.counter), 0);
                chk("rnd_rst_led3", int'(led3), 1);
                n_rst3 = 1'b1;
                #1;
            end else if (n >= 30 && $urandom_range(0, 11) == 0) begin
                n_rst1 = 1'b0;
                #1;
                k1 = 0;
                chk("rnd_rst_led1", int'(led1), 0);
                n_rst1 = 1'b1;
                #1;
            end else begin
                tick();
                k3++;
                k1++;
                // level flips after each full CDIV edges since reset
                chk("rnd_cnt3", int'(dut3.counter), k3 % 3);
                chk("rnd_led3", int'(led3), 1 ^ ((k3 / 3) % 2));
                chk("rnd_cnt3_range", int'(dut3.counter < 2'd3), 1);
                chk("rnd_cnt1", int'(dut1.counter), 0);
                chk("rnd_led1", int'(led1), k1 % 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
